// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: control and status bundle between a player host and tone_sequencer.
// Carries the start/stop/loop_en requests in and buzz/busy/done/note_idx status out.
// The host uses the master view, the sequencer uses the slave view.
interface tone_sequencer_if #(
   parameter int NOTES = 8
);
   localparam int IW = $clog2(NOTES);

   logic          start;
   logic          stop;
   logic          loop_en;
   logic          buzz;
   logic          busy;
   logic          done;
   logic [IW-1:0] note_idx;

   modport master (
      output start, stop, loop_en,
      input  buzz, busy, done, note_idx
   );

   modport slave (
      input  start, stop, loop_en,
      output buzz, busy, done, note_idx
   );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a melody from the TABLE parameter onto a piezo pin. Each entry is a
//   (half-period, count) pair; count==0 terminates the song, half-period==0 is a rest timed by REST_HP.
// Latency: busy rises the cycle after start; each entry costs 1 LOAD cycle + 2*cnt*H TONE cycles.
// Backpressure: none; start while busy is ignored, stop aborts on the next edge with no done pulse.
// Ports: hwclk/rst (sync, active-high); bus.start/stop/loop_en in; bus.buzz/busy/done/note_idx out.
// Build option: define TONE_SEQ_GAP_EN to insert GAP_CLKS silent clocks after every non-final entry.
module tone_sequencer #(
   parameter int NOTES   = 8,
   parameter int HP_W    = 16,
   parameter int CNT_W   = 16,
   parameter int REST_HP = 1024,
`ifdef TONE_SEQ_GAP_EN
   parameter int GAP_CLKS = 256,
`endif
   parameter logic [NOTES*(HP_W+CNT_W)-1:0] TABLE = '0
) (
   input logic             hwclk,
   input logic             rst,
   tone_sequencer_if.slave bus
);
   localparam int              EW       = HP_W + CNT_W;
   localparam int              IW       = $clog2(NOTES);
   localparam logic [HP_W-1:0] REST_H   = HP_W'(REST_HP);
   localparam logic [HP_W-1:0] HP_ONE   = HP_W'(1);
   localparam logic [CNT_W:0]  HALF_ONE = (CNT_W+1)'(1);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NOTES - 1);
`ifdef TONE_SEQ_GAP_EN
   localparam int              GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CLKS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, TONE} state_t;
`endif

   state_t            state, state_nxt;
   logic [IW-1:0]     note_idx, idx_nxt;
   logic [HP_W-1:0]   hp, hp_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [HP_W-1:0]   phase, phase_nxt;
   logic [CNT_W:0]    halves, halves_nxt;   // one extra bit so 2*cnt-1 never overflows
   logic              buzz, buzz_nxt;
   logic              busy, busy_nxt;
   logic              done, done_nxt;
   logic              song_end;
`ifdef TONE_SEQ_GAP_EN
   logic [GW-1:0]     gap_cnt, gap_nxt;
`endif

   logic [EW-1:0]     entry;
   logic [HP_W-1:0]   entry_hp;
   logic [CNT_W-1:0]  entry_cnt;
   logic [HP_W-1:0]   h_eff;
   logic [CNT_W:0]    last_half;

   assign entry     = TABLE[note_idx*EW +: EW];
   assign entry_hp  = entry[HP_W-1:0];
   assign entry_cnt = entry[EW-1:HP_W];
   // Rests run the same half-period machinery on REST_HP but never toggle the pin.
   assign h_eff     = (hp == '0) ? REST_H : hp;
   // Index of the final half-period of the current entry.
   assign last_half = {cnt, 1'b0} - HALF_ONE;

   always_ff @(posedge hwclk) begin
      if (rst) begin
         state    <= IDLE;
         note_idx <= '0;
         hp       <= '0;
         cnt      <= '0;
         phase    <= '0;
         halves   <= '0;
         buzz     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
`ifdef TONE_SEQ_GAP_EN
         gap_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         note_idx <= idx_nxt;
         hp       <= hp_nxt;
         cnt      <= cnt_nxt;
         phase    <= phase_nxt;
         halves   <= halves_nxt;
         buzz     <= buzz_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
`ifdef TONE_SEQ_GAP_EN
         gap_cnt  <= gap_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = note_idx;
      hp_nxt     = hp;
      cnt_nxt    = cnt;
      phase_nxt  = phase;
      halves_nxt = halves;
      buzz_nxt   = buzz;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      song_end   = 1'b0;
`ifdef TONE_SEQ_GAP_EN
      gap_nxt    = gap_cnt;
`endif
      // stop wins over start and over everything in flight; in IDLE it is a harmless clear.
      if (bus.stop) begin
         state_nxt  = IDLE;
         idx_nxt    = '0;
         phase_nxt  = '0;
         halves_nxt = '0;
         buzz_nxt   = 1'b0;
         busy_nxt   = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_nxt = LOAD;
                  idx_nxt   = '0;
                  busy_nxt  = 1'b1;
               end
            end
            LOAD: begin
               hp_nxt     = entry_hp;
               cnt_nxt    = entry_cnt;
               phase_nxt  = '0;
               halves_nxt = '0;
               buzz_nxt   = 1'b0;
               if (entry_cnt == '0) song_end  = 1'b1;
               else                 state_nxt = TONE;
            end
            TONE: begin
               if (phase == h_eff - HP_ONE) begin
                  phase_nxt  = '0;
                  halves_nxt = halves + HALF_ONE;
                  if (hp != '0) buzz_nxt = ~buzz;
                  if (halves == last_half) begin
                     buzz_nxt = 1'b0;
                     if (note_idx == LAST_IDX) begin
                        song_end = 1'b1;
                     end else begin
                        idx_nxt = note_idx + IW'(1);
`ifdef TONE_SEQ_GAP_EN
                        if (GAP_CLKS > 0) begin
                           state_nxt = GAP;
                           gap_nxt   = '0;
                        end else begin
                           state_nxt = LOAD;
                        end
`else
                        state_nxt = LOAD;
`endif
                     end
                  end
               end else begin
                  phase_nxt = phase + HP_ONE;
               end
            end
`ifdef TONE_SEQ_GAP_EN
            GAP: begin
               if (gap_cnt == GAP_LAST) state_nxt = LOAD;
               else                     gap_nxt   = gap_cnt + GW'(1);
            end
`endif
            default: state_nxt = IDLE;
         endcase

         // loop_en is only looked at here, at the moment the song ends.
         if (song_end) begin
            done_nxt = 1'b1;
            if (bus.loop_en) begin
               idx_nxt   = '0;
               state_nxt = LOAD;
            end else begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
            end
         end
      end
   end

   assign bus.buzz     = buzz;
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.note_idx = note_idx;
endmodule
